// File: rtl/silencer_cfg_reader.sv
// Silencer configuration reader: watches CTL_FLAG in controller BRAM for a rising
// SILENCER_SET bit, fetches the five silencer words and commits them atomically.
module silencer_cfg_reader #(
    parameter int ReadLatency = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [7:0]  BRAM_ADDR,
    input  logic [15:0] BRAM_DOUT,
    output logic [15:0] UPDATE_RATE_INTENSITY,
    output logic [15:0] UPDATE_RATE_PHASE,
    output logic [15:0] COMPLETION_STEPS_INTENSITY,
    output logic [15:0] COMPLETION_STEPS_PHASE,
    output logic        FIXED_UPDATE_RATE_MODE,
    output logic        PULSE_WIDTH,
    output logic        UPDATE,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        POLL    = 2'd0,
        FETCH   = 2'd1,
        COLLECT = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam int         NumWords    = 5;
    localparam int         NumSettings = 4;
    localparam logic [7:0] FlagAddr    = 8'h00;
    localparam logic [7:0] CfgBase     = 8'h40;
    localparam logic [7:0] LatCount    = 8'(ReadLatency);
    localparam logic [7:0] LastIssue   = 8'(NumWords - 1);
    localparam logic [7:0] LastCapture = 8'(NumWords - 1 + ReadLatency);
    localparam int         SetBit      = 2;

    // Settings order matches the word order at 0x41..0x44.
    localparam logic [15:0] SettingReset [NumSettings] = '{16'd256, 16'd256, 16'd10, 16'd40};

    state_t                      state_reg, state_next;
    logic [7:0]                  cnt_reg, cnt_next;
    logic [7:0]                  disc_reg, disc_next;
    logic                        prev_flag_reg, prev_flag_next;
    logic [NumWords-1:0][15:0]   shadow_reg;
    logic [1:0]                  flags_reg;
    logic                        update_reg;
    logic                        sample_valid;
    logic                        capture_en;
    logic                        commit_en;
    logic [7:0]                  capture_idx;

    function automatic logic [15:0] clamp_zero(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= POLL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Data arriving in the first ReadLatency POLL cycles belongs to earlier addresses.
    assign sample_valid = (state_reg == POLL) && (disc_reg == LatCount);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            POLL: begin
                if (sample_valid && BRAM_DOUT[SetBit] && !prev_flag_reg) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (cnt_reg == LastIssue) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (cnt_reg == LastCapture) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = POLL;
            end
            default: begin
                state_next = POLL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        BRAM_ADDR  = FlagAddr;
        BUSY       = 1'b1;
        capture_en = 1'b0;
        commit_en  = 1'b0;
        case (state_reg)
            POLL: begin
                BUSY = 1'b0;
            end
            FETCH: begin
                BRAM_ADDR  = CfgBase + cnt_reg;
                capture_en = (cnt_reg >= LatCount);
            end
            COLLECT: begin
                BRAM_ADDR  = CfgBase + LastIssue;
                capture_en = (cnt_reg >= LatCount);
            end
            COMMIT: begin
                commit_en = 1'b1;
            end
            default: begin
                BUSY = 1'b1;
            end
        endcase
    end

    // The word returning now was addressed ReadLatency cycles ago.
    assign capture_idx = cnt_reg - LatCount;

    // ------------------------------------------------------------------
    // Counters and edge-detect state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next       = 8'd0;
        disc_next      = 8'd0;
        prev_flag_next = prev_flag_reg;
        if (state_reg == FETCH || state_reg == COLLECT) begin
            cnt_next = cnt_reg + 8'd1;
        end
        if (state_reg == POLL) begin
            disc_next = (disc_reg == LatCount) ? disc_reg : disc_reg + 8'd1;
        end
        if (sample_valid) begin
            prev_flag_next = BRAM_DOUT[SetBit];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_reg       <= 8'd0;
            disc_reg      <= 8'd0;
            prev_flag_reg <= 1'b0;
            shadow_reg    <= '0;
            flags_reg     <= 2'b00;
            update_reg    <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            disc_reg      <= disc_next;
            prev_flag_reg <= prev_flag_next;
            update_reg    <= commit_en;
            if (commit_en) begin
                flags_reg <= shadow_reg[0][1:0];
            end
            for (int i = 0; i < NumWords; i++) begin
                if (capture_en && (capture_idx == 8'(i))) begin
                    shadow_reg[i] <= BRAM_DOUT;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Committed settings: all load together on the COMMIT edge only
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NumSettings; gi++) begin : g_setting
            logic [15:0] setting_reg;
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    setting_reg <= SettingReset[gi];
                end else if (commit_en) begin
                    setting_reg <= clamp_zero(shadow_reg[gi+1]);
                end
            end
        end
    endgenerate

    assign UPDATE_RATE_INTENSITY      = g_setting[0].setting_reg;
    assign UPDATE_RATE_PHASE          = g_setting[1].setting_reg;
    assign COMPLETION_STEPS_INTENSITY = g_setting[2].setting_reg;
    assign COMPLETION_STEPS_PHASE     = g_setting[3].setting_reg;
    assign FIXED_UPDATE_RATE_MODE     = flags_reg[0];
    assign PULSE_WIDTH                = flags_reg[1];
    assign UPDATE                     = update_reg;

endmodule

// File: tb/tb_silencer_cfg_reader.sv
// Directed bench for silencer_cfg_reader: one DUT at ReadLatency 2 and one at 3,
// each fed by a behavioural pipelined BRAM model.
module tb_silencer_cfg_reader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  addr2, addr3;
    logic [15:0] dout2, dout3;
    logic [15:0] uri2, urp2, csi2, csp2, uri3, urp3, csi3, csp3;
    logic        fixed2, pw2, update2, busy2, fixed3, pw3, update3, busy3;

    silencer_cfg_reader #(.ReadLatency(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .BRAM_ADDR(addr2), .BRAM_DOUT(dout2),
        .UPDATE_RATE_INTENSITY(uri2), .UPDATE_RATE_PHASE(urp2),
        .COMPLETION_STEPS_INTENSITY(csi2), .COMPLETION_STEPS_PHASE(csp2),
        .FIXED_UPDATE_RATE_MODE(fixed2), .PULSE_WIDTH(pw2),
        .UPDATE(update2), .BUSY(busy2)
    );

    silencer_cfg_reader #(.ReadLatency(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .BRAM_ADDR(addr3), .BRAM_DOUT(dout3),
        .UPDATE_RATE_INTENSITY(uri3), .UPDATE_RATE_PHASE(urp3),
        .COMPLETION_STEPS_INTENSITY(csi3), .COMPLETION_STEPS_PHASE(csp3),
        .FIXED_UPDATE_RATE_MODE(fixed3), .PULSE_WIDTH(pw3),
        .UPDATE(update3), .BUSY(busy3)
    );

    // BRAM models: address sampled on the edge, data valid N cycles after the address cycle
    logic [15:0] mem2 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] pipe2 [0:1];
    logic [15:0] pipe3 [0:2];

    always @(posedge clk) begin
        pipe2[0] <= mem2[addr2];
        pipe2[1] <= pipe2[0];
        pipe3[0] <= mem3[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout2 = pipe2[1];
    assign dout3 = pipe3[2];

    localparam logic [65:0] DefaultOuts = {16'd256, 16'd256, 16'd10, 16'd40, 1'b0, 1'b0};
    localparam logic [65:0] BasicOuts   = {16'd256, 16'd128, 16'd10, 16'd40, 1'b1, 1'b1};

    int checks = 0;
    int errors = 0;

    logic        sel = 1'b0;
    logic        m_busy, m_update;
    logic [7:0]  m_addr;
    logic [65:0] m_outs;
    assign m_busy   = sel ? busy3 : busy2;
    assign m_update = sel ? update3 : update2;
    assign m_addr   = sel ? addr3 : addr2;
    assign m_outs   = sel ? {uri3, urp3, csi3, csp3, fixed3, pw3}
                          : {uri2, urp2, csi2, csp2, fixed2, pw2};

    logic [7:0] addr_log [0:20];
    logic       early_change;
    int         poke_step = -1;
    int         lat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic which, input int a, input logic [15:0] d);
        if (which) mem3[a] = d;
        else       mem2[a] = d;
    endtask

    task automatic load_cfg(input logic which, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
        set_word(which, 8'h40, w0);
        set_word(which, 8'h41, w1);
        set_word(which, 8'h42, w2);
        set_word(which, 8'h43, w3);
        set_word(which, 8'h44, w4);
    endtask

    // Force a clean low sample, then raise SILENCER_SET.
    task automatic arm(input logic which);
        set_word(which, 0, 16'h0000);
        repeat (6) step();
        set_word(which, 0, 16'h0004);
    endtask

    // Waits for FETCH entry and counts cycles to UPDATE; lat = -1 on timeout.
    task automatic measure(output int latency);
        logic [65:0] snap;
        latency      = -1;
        early_change = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_busy) break;
            step();
        end
        if (!m_busy) return;
        snap        = m_outs;
        addr_log[0] = m_addr;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == poke_step) set_word(sel, 8'h42, 16'hBEEF);
            addr_log[n] = m_addr;
            if (m_update) begin
                latency = n;
                return;
            end
            if (m_outs !== snap) early_change = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (addr2 !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", addr2); end
        checks++; if (update2 !== 1'b0) begin errors++; $display("FAIL reset_update: got %b expected 0", update2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy2); end
        checks++; if (uri2 !== 16'd256) begin errors++; $display("FAIL reset_uri: got %0d expected 256", uri2); end
        checks++; if (urp2 !== 16'd256) begin errors++; $display("FAIL reset_urp: got %0d expected 256", urp2); end
        checks++; if (csi2 !== 16'd10) begin errors++; $display("FAIL reset_csi: got %0d expected 10", csi2); end
        checks++; if (csp2 !== 16'd40) begin errors++; $display("FAIL reset_csp: got %0d expected 40", csp2); end
        checks++; if ({fixed2, pw2} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {fixed2, pw2}); end
        checks++; if ({uri3, urp3, csi3, csp3, fixed3, pw3, busy3} !== {DefaultOuts, 1'b0}) begin
            errors++; $display("FAIL reset_dut3: got %h expected %h", {uri3, urp3, csi3, csp3, fixed3, pw3, busy3}, {DefaultOuts, 1'b0});
        end
        rst_n = 1'b1;
        repeat (6) step();
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy2); end
        $display("test_reset done");
    endtask

    task automatic test_basic_load();
        sel = 1'b0;
        load_cfg(0, 16'h0003, 16'h0100, 16'h0080, 16'h000A, 16'h0028);
        arm(0);
        measure(lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (addr_log[0] !== 8'h40) begin errors++; $display("FAIL basic_addr0: got %h expected 40", addr_log[0]); end
        checks++; if (addr_log[1] !== 8'h41) begin errors++; $display("FAIL basic_addr1: got %h expected 41", addr_log[1]); end
        checks++; if (addr_log[3] !== 8'h43) begin errors++; $display("FAIL basic_addr3: got %h expected 43", addr_log[3]); end
        checks++; if (addr_log[4] !== 8'h44) begin errors++; $display("FAIL basic_addr4: got %h expected 44", addr_log[4]); end
        checks++; if (addr_log[6] !== 8'h44) begin errors++; $display("FAIL basic_collect_addr: got %h expected 44", addr_log[6]); end
        checks++; if (early_change !== 1'b0) begin errors++; $display("FAIL basic_early_change: got %b expected 0", early_change); end
        checks++; if (m_outs !== BasicOuts) begin errors++; $display("FAIL basic_outputs: got %h expected %h", m_outs, BasicOuts); end
        step();
        checks++; if (update2 !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", update2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy2); end
        $display("test_basic_load done: latency %0d", lat);
    endtask

    task automatic test_level_hold();
        int pulses;
        sel = 1'b0;
        load_cfg(0, 16'h0001, 16'h1234, 16'hFFFF, 16'h0002, 16'h8000);
        arm(0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (update2) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
        checks++; if (m_outs !== {16'h1234, 16'hFFFF, 16'd2, 16'h8000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hold_outputs: got %h expected %h", m_outs, {16'h1234, 16'hFFFF, 16'd2, 16'h8000, 1'b1, 1'b0});
        end
        load_cfg(0, 16'h0002, 16'h0007, 16'h0009, 16'h000B, 16'h000D);
        set_word(0, 0, 16'h0000);
        step();
        set_word(0, 0, 16'h0004);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (update2) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL retrigger_pulses: got %0d expected 1", pulses); end
        checks++; if (m_outs !== {16'd7, 16'd9, 16'd11, 16'd13, 1'b0, 1'b1}) begin
            errors++; $display("FAIL retrigger_outputs: got %h expected %h", m_outs, {16'd7, 16'd9, 16'd11, 16'd13, 1'b0, 1'b1});
        end
        $display("test_level_hold done");
    endtask

    task automatic test_clamp();
        sel = 1'b0;
        load_cfg(0, 16'hFFFC, 16'h0000, 16'h0000, 16'h0007, 16'h0000);
        arm(0);
        measure(lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL clamp_latency: got %0d expected 8", lat); end
        checks++; if (m_outs !== {16'd1, 16'd1, 16'd7, 16'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clamp_outputs: got %h expected %h", m_outs, {16'd1, 16'd1, 16'd7, 16'd1, 1'b0, 1'b0});
        end
        $display("test_clamp done");
    endtask

    task automatic test_atomicity();
        sel = 1'b0;
        load_cfg(0, 16'h0002, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        arm(0);
        poke_step = 5;
        measure(lat);
        poke_step = -1;
        checks++; if (lat != 8) begin errors++; $display("FAIL atomic_latency: got %0d expected 8", lat); end
        checks++; if (early_change !== 1'b0) begin errors++; $display("FAIL atomic_early_change: got %b expected 0", early_change); end
        checks++; if (m_outs !== {16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 1'b1}) begin
            errors++; $display("FAIL atomic_outputs: got %h expected %h", m_outs, {16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 1'b1});
        end
        $display("test_atomicity done");
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        load_cfg(0, 16'h0003, 16'h0100, 16'h0080, 16'h000A, 16'h0028);
        arm(0);
        for (int i = 0; i < 60; i++) begin
            if (busy2) break;
            step();
        end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL midreset_fetch_start: got %b expected 1", busy2); end
        repeat (5) step();
        rst_n = 1'b0;
        step();
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy2); end
        checks++; if (update2 !== 1'b0) begin errors++; $display("FAIL midreset_update: got %b expected 0", update2); end
        checks++; if (addr2 !== 8'h00) begin errors++; $display("FAIL midreset_addr: got %h expected 00", addr2); end
        checks++; if (m_outs !== DefaultOuts) begin errors++; $display("FAIL midreset_outputs: got %h expected %h", m_outs, DefaultOuts); end
        step();
        checks++; if (update2 !== 1'b0) begin errors++; $display("FAIL midreset_update2: got %b expected 0", update2); end
        rst_n = 1'b1;
        $display("test_reset_mid done");
    endtask

    task automatic test_flag_high_at_reset();
        sel = 1'b0;
        measure(lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL highreset_latency: got %0d expected 8", lat); end
        checks++; if (m_outs !== BasicOuts) begin errors++; $display("FAIL highreset_outputs: got %h expected %h", m_outs, BasicOuts); end
        $display("test_flag_high_at_reset done: latency %0d", lat);
    endtask

    task automatic test_latency3();
        sel = 1'b1;
        load_cfg(1, 16'h0003, 16'h0100, 16'h0080, 16'h000A, 16'h0028);
        arm(1);
        measure(lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL rl3_latency: got %0d expected 9", lat); end
        checks++; if (addr_log[0] !== 8'h40) begin errors++; $display("FAIL rl3_addr0: got %h expected 40", addr_log[0]); end
        checks++; if (addr_log[7] !== 8'h44) begin errors++; $display("FAIL rl3_collect_addr: got %h expected 44", addr_log[7]); end
        checks++; if (early_change !== 1'b0) begin errors++; $display("FAIL rl3_early_change: got %b expected 0", early_change); end
        checks++; if (m_outs !== BasicOuts) begin errors++; $display("FAIL rl3_outputs: got %h expected %h", m_outs, BasicOuts); end
        sel = 1'b0;
        $display("test_latency3 done: latency %0d", lat);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem2[i] = 16'h0000;
            mem3[i] = 16'h0000;
        end
        test_reset();
        test_basic_load();
        test_level_hold();
        test_clamp();
        test_atomicity();
        test_reset_mid();
        test_flag_high_at_reset();
        test_latency3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
